// File: rtl/calc_btn_cond_pkg.sv
// Shared constants for the calculator input conditioner: button indices,
// channel count and the default debounce interval.
package calc_btn_cond_pkg;

  // Bit positions of each pushbutton within the 5-bit button buses
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_U = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  localparam int NUM_BTN = 5;

  // 10 ms at a 100 MHz system clock
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/calc_btn_cond_debounce_ch.sv
// One pushbutton channel: a 2-flop synchroniser followed by a saturating
// qualification counter. The debounced level only follows the synchronised
// input after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
// A one-cycle strobe marks every accepted 0->1 transition.
module debounce_ch
  import calc_btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_lvl;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous button into the clk domain through two flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Qualify changes of the synchronised input; any return to the stable
  // level restarts the count, so bounces never reach the outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lvl   <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (r_s2 == r_lvl) begin
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_lvl   <= r_s2;
      r_cnt   <= '0;
      r_press <= r_s2;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_press <= 1'b0;
    end
  end

  assign o_lvl   = r_lvl;
  assign o_press = r_press;

endmodule

// File: rtl/calc_btn_cond.sv
// Input conditioner for the calculator: debounced button levels and press
// strobes for the five pushbuttons, plus a synchronised copy of the switches.
// Switches are only synchronised, not debounced, so they lag by two edges.
module calc_btn_cond
  import calc_btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [NUM_BTN-1:0]  btn_lvl,
  output logic [NUM_BTN-1:0]  btn_press,
  output logic [SW_WIDTH-1:0] sw_sync
);

  logic [SW_WIDTH-1:0] r_swS1;
  logic [SW_WIDTH-1:0] r_swS2;

  // Each button gets its own fully independent debounce channel
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (btn_raw[g]),
      .o_lvl  (btn_lvl[g]),
      .o_press(btn_press[g])
    );
  end

  // Two-flop synchroniser for the switch bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_swS1 <= '0;
      r_swS2 <= '0;
    end else begin
      r_swS1 <= sw_raw;
      r_swS2 <= r_swS1;
    end
  end

  assign sw_sync = r_swS2;

endmodule

// File: tb/tb_calc_btn_cond.sv
// Directed bench for calc_btn_cond with a short debounce interval.
// Edge numbering: applyStimulus drives inputs, lets one rising edge sample
// them, then returns 1 ns later so outputs can be checked after that edge.
module tb_calc_btn_cond;

  localparam int DEB = 4;
  localparam int SW  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    btn_raw = '0;
  logic [SW-1:0] sw_raw = '0;
  logic [4:0]    btn_lvl;
  logic [4:0]    btn_press;
  logic [SW-1:0] sw_sync;

  int checkCount = 0;
  int errorCount = 0;

  calc_btn_cond #(
    .DEBOUNCE_CYCLES(DEB),
    .SW_WIDTH       (SW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .sw_raw   (sw_raw),
    .btn_lvl  (btn_lvl),
    .btn_press(btn_press),
    .sw_sync  (sw_sync)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive raw inputs, let one rising edge sample them, step just past it
  task automatic applyStimulus(input logic [4:0] btn, input logic [SW-1:0] sw);
    btn_raw = btn;
    sw_raw  = sw;
    @(posedge clk);
    #1;
  endtask

  // Safety net so the run always ends even if the sequence stalls
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    logic [4:0] b;

    // Reset state with busy inputs: nothing may propagate while reset is high
    repeat (3) applyStimulus(5'h1F, 16'hFFFF);
    checkOutput("rst_lvl",   btn_lvl,   0);
    checkOutput("rst_press", btn_press, 0);
    checkOutput("rst_sw",    sw_sync,   0);
    repeat (2) applyStimulus(5'h00, 16'h0000);
    reset = 1'b0;
    repeat (3) applyStimulus(5'h00, 16'h0000);
    checkOutput("idle_lvl", btn_lvl, 0);

    // Clean press on btn d (bit 4), held to edge 29, released at edge 30
    for (int e = 0; e <= 40; e++) begin
      b = (e < 30) ? 5'b10000 : 5'b00000;
      applyStimulus(b, 16'h0000);
      checkOutput($sformatf("press_lvl_e%0d", e), btn_lvl,
                  (e >= 5 && e < 35) ? 5'b10000 : 5'b00000);
      checkOutput($sformatf("press_str_e%0d", e), btn_press,
                  (e == 5) ? 5'b10000 : 5'b00000);
    end

    // Bounce on btn c (bit 0): 1,0,1,0 then held; last rising sample edge 4
    for (int e = 0; e <= 15; e++) begin
      b = (e < 4 && (e % 2) == 1) ? 5'b00000 : 5'b00001;
      applyStimulus(b, 16'h0000);
      checkOutput($sformatf("bounce_lvl_e%0d", e), btn_lvl,
                  (e >= 9) ? 5'b00001 : 5'b00000);
      checkOutput($sformatf("bounce_str_e%0d", e), btn_press,
                  (e == 9) ? 5'b00001 : 5'b00000);
    end
    repeat (8) applyStimulus(5'h00, 16'h0000);
    checkOutput("bounce_release_lvl", btn_lvl, 0);

    // Reset in the middle of qualifying btn u (bit 2)
    for (int e = 0; e <= 3; e++) applyStimulus(5'b00100, 16'h0000);
    reset = 1'b1;
    #1;
    checkOutput("midrst_async_lvl",   btn_lvl,   0);
    checkOutput("midrst_async_press", btn_press, 0);
    for (int e = 0; e < 2; e++) begin
      applyStimulus(5'b00100, 16'h0000);
      checkOutput($sformatf("midrst_hold_lvl_%0d", e),   btn_lvl,   0);
      checkOutput($sformatf("midrst_hold_press_%0d", e), btn_press, 0);
    end
    reset = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      applyStimulus(5'b00100, 16'h0000);
      checkOutput($sformatf("postrst_lvl_e%0d", e), btn_lvl,
                  (e >= 5) ? 5'b00100 : 5'b00000);
      checkOutput($sformatf("postrst_str_e%0d", e), btn_press,
                  (e == 5) ? 5'b00100 : 5'b00000);
    end
    repeat (8) applyStimulus(5'h00, 16'h0000);
    checkOutput("postrst_release_lvl", btn_lvl, 0);

    // All buttons together plus a switch pattern
    for (int e = 0; e <= 8; e++) begin
      applyStimulus(5'b11111, 16'hA5C3);
      checkOutput($sformatf("all_sw_e%0d", e), sw_sync,
                  (e >= 1) ? 16'hA5C3 : 16'h0000);
      checkOutput($sformatf("all_lvl_e%0d", e), btn_lvl,
                  (e >= 5) ? 5'b11111 : 5'b00000);
      checkOutput($sformatf("all_str_e%0d", e), btn_press,
                  (e == 5) ? 5'b11111 : 5'b00000);
    end

    // Switch change: exactly two edges of lag
    applyStimulus(5'b11111, 16'h3C5A);
    checkOutput("sw_lag_e0", sw_sync, 16'hA5C3);
    applyStimulus(5'b11111, 16'h3C5A);
    checkOutput("sw_lag_e1", sw_sync, 16'h3C5A);
    checkOutput("hold_no_repeat", btn_press, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
